// File: rtl/gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe_if.sv
// Bus for the pipelined NOR/OR reduction block: stall enable, input valid,
// packed channel inputs, registered result and result valid.
interface gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
) ();
  logic                      EN;
  logic                      VI;
  logic [CHANNELS*WIDTH-1:0] A;
  logic [CHANNELS-1:0]       Y;
  logic                      VO;

  // Upstream producer / result consumer side.
  modport master (
    output EN,
    output VI,
    output A,
    input  Y,
    input  VO
  );

  // Reduction pipeline side.
  modport slave (
    input  EN,
    input  VI,
    input  A,
    output Y,
    output VO
  );
endinterface

// File: rtl/gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe.sv
// Multi-channel wide NOR (or OR) reduction followed by a STAGES-deep
// register pipeline with a valid bit and a global stall enable. Data
// registers only load when the value feeding them is valid, so idle
// cycles do not toggle the data path and Y keeps the last valid result.
module gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int STAGES   = 2,
  parameter int INVERT   = 1
) (
  input logic CLK,
  input logic RN,
  gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe_if.slave bus
);

  // Reject illegal configurations at elaboration rather than clamping them.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe: WIDTH must be 2..16");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe: CHANNELS must be 1..8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe: STAGES must be 1..4");
  end
  if (INVERT < 0 || INVERT > 1) begin : g_bad_invert
    $error("gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe: INVERT must be 0 or 1");
  end

  logic [CHANNELS-1:0]              red_s;
  logic [STAGES-1:0][CHANNELS-1:0]  data_q;
  logic [STAGES-1:0][CHANNELS-1:0]  data_d;
  logic [STAGES-1:0]                valid_q;
  logic [STAGES-1:0]                valid_d;

  // Per-channel reduction of the raw inputs; channels never interact.
  always_comb begin
    red_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (INVERT != 0) begin
        red_s[c] = ~(|bus.A[c*WIDTH +: WIDTH]);
      end else begin
        red_s[c] = |bus.A[c*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for every stage: advance only on EN, load data only when valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (bus.EN) begin
      valid_d[0] = bus.VI;
      if (bus.VI) begin
        data_d[0] = red_s;
      end else begin
        data_d[0] = data_q[0];
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
        end else begin
          data_d[k] = data_q[k];
        end
      end
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
    end
  end

  // Pipeline registers; asynchronous reset drops everything in flight.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Y  = data_q[STAGES-1];
  assign bus.VO = valid_q[STAGES-1];

endmodule

// File: doc/gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe.md
Name: gf180mcu_osu_sc_gp9t3v3_nor_reduce_pipe

Overview:
- Parametrised, pipelined, multi-channel N-input NOR for the gp9t3v3 library.
- Each channel reduces WIDTH input bits to one output bit, selectable between NOR and OR.
- Results pass through a STAGES-deep register pipeline with a valid bit and a global stall enable.
- Used wherever wide zero-detect / any-set flags must close timing at 3.3 V; replaces chains of 2-input NOR cells plus flops.

Parameters:
- WIDTH, 4: input bits per channel; legal 2..16.
- CHANNELS, 2: independent reduction channels; legal 1..8.
- STAGES, 2: pipeline depth in cycles; legal 1..4.
- INVERT, 1: 1 = NOR (output high when all inputs low); 0 = OR.

Ports:
- CLK, input, 1: clock, rising edge.
- RN, input, 1: asynchronous active-low reset.
- EN, input, 1: pipeline advance enable; 0 = stall.
- VI, input, 1: input valid.
- A, input, CHANNELS*WIDTH: channel c uses bits A[c*WIDTH +: WIDTH].
- Y, output, CHANNELS: registered reduction result, bit c for channel c.
- VO, output, 1: Y valid.

Behaviour:
- Reset: RN low asynchronously clears every pipeline data register, every valid register, Y and VO to 0. This holds regardless of CLK/EN. Release is synchronous to the next CLK edge after RN rises.
- Function per channel: r[c] = INVERT ? ~|A[c] : |A[c]. Computed combinationally from A in the first stage. Channels are fully independent.
- Stage 1 captures on a rising CLK edge when EN=1:
  - valid1 <= VI.
  - data1 <= r only if VI=1; otherwise data1 holds its value (power gating).
- Stage k (2..STAGES) captures on a rising CLK edge when EN=1:
  - valid_k <= valid_(k-1).
  - data_k <= data_(k-1) only if valid_(k-1)=1; otherwise data_k holds.
- Outputs: Y = data_STAGES, VO = valid_STAGES.
- Latency: with EN held high, VI/A sampled at edge n appear on Y/VO after edge n+STAGES-1, i.e. visible for the cycle following that edge. STAGES=1 gives a single registered stage.
- Throughput: one result per cycle; no bubbles are inserted.
- Stall: EN=0 freezes all data and valid registers, including Y/VO. Inputs presented during a stall are dropped; the upstream stage must hold VI/A.
- Hold-after-invalid: when VO=0, Y keeps the last valid result. It does not return to 0 except on reset.
- Reset mid-operation: all in-flight results are lost. VO is 0 on the first edge after release and stays 0 until a new VI=1 propagates the full STAGES edges.
- Simultaneous RN low with EN/VI high: reset wins.
- Out-of-range parameters: elaboration error via generate-time check. Not to be silently clamped.

Test Plan:
- Default params: RN low, then high; A=8'h00, VI=1, EN=1 at edge 0 -> Y=2'b11, VO=1 after edge 1; VO=0 and Y=0 before that.
- A=8'h10, VI=1 -> channel 0 input 4'h0, channel 1 input 4'h1 -> Y=2'b01 two edges later. With INVERT=0 the same stimulus gives Y=2'b10.
- Back-to-back stream A=00,F0,0F,FF with VI=1 every cycle -> Y sequence 11,01,10,00 on consecutive cycles. VO stays 1 throughout.
- Stall: EN=0 for 3 cycles mid-stream -> Y/VO frozen for 3 cycles, then the sequence resumes with no loss or duplication of pre-stall values.
- Bubble: VI=0 for one cycle between A=00 and A=FF -> VO drops for exactly one cycle. Y holds 2'b11 during the bubble, then becomes 2'b00.
- Reset mid-flight: assert RN low asynchronously between edges with 2 results in flight -> Y=0 and VO=0 immediately. After release, VO stays 0 until a new VI=1 completes STAGES edges.
- Sweep: WIDTH=16, CHANNELS=8, STAGES=4 -> random A checked against a reference model at latency 4.
